ibex_imem_fill: RTL and testbench

- Initiator side of the instruction-memory SRAM port (req / gnt / rvalid) used by the ibex cache benchmark.
- Takes a line-fill request from the I-cache miss logic and issues LINE_WORDS single-word reads to the imem responder.
- Assembles the returned words into a line buffer, then pulses completion with the full line.
- Sits between the I-cache tag/miss controller and the imem.

---
 rtl/ibex_imem_fill_pkg.sv | 18 +
 rtl/ibex_imem_line_buf.sv | 32 +++
 rtl/ibex_imem_fill.sv | 139 +++++++++++++
 tb/tb_ibex_imem_fill.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_imem_fill_pkg.sv
// Shared types and constants for the imem line-fill initiator.
// Used by ibex_imem_fill and ibex_imem_line_buf.
package ibex_imem_fill_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } fill_st_e;

  function automatic int off_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ibex_imem_line_buf.sv
// Line assembly buffer: one write port addressed by slot index.
// Contents persist until overwritten; reset zeroes every slot.
module ibex_imem_line_buf
  import ibex_imem_fill_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int OW         = off_w(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_we,
  input  logic [OW-1:0]                i_slot,
  input  logic [WORD_W-1:0]            i_data,
  output logic [LINE_WORDS*WORD_W-1:0] o_line
);

  logic [WORD_W-1:0] r_mem [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++)
        r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_slot] <= i_data;
    end
  end

  for (genvar i = 0; i < LINE_WORDS; i++) begin : g_out
    assign o_line[i*WORD_W +: WORD_W] = r_mem[i];
  end

endmodule

// File: rtl/ibex_imem_fill.sv
// I-cache line-fill initiator on the imem req/gnt/rvalid port.
// IBEX_IMEM_FILL_CRIT_WORD_FIRST_EN: start at the missing word.
module ibex_imem_fill
  import ibex_imem_fill_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fill_req,
  input  logic [ADDR_W-1:0]            fill_addr,
  input  logic                         fill_abort,
  output logic                         fill_ready,
  output logic                         fill_done,
  output logic [ADDR_W-1:0]            fill_base,
  output logic [LINE_WORDS*WORD_W-1:0] fill_line,
  output logic                         sram_req,
  output logic [ADDR_W-1:0]            sram_addr,
  input  logic                         sram_gnt,
  input  logic                         sram_rvalid,
  input  logic [WORD_W-1:0]            sram_rdata,
  output logic                         proto_err
);

  localparam int OW = off_w(LINE_WORDS);
  localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);

  fill_st_e          r_st;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_base;
  logic [OW-1:0]     r_cnt;
  logic              r_done;
  logic              r_err;
  logic              r_first;

  logic              w_hs;
  logic              w_we;
  logic [OW-1:0]     w_off;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_start;
  logic [ADDR_W-1:0] w_next;

  assign w_hs   = r_req & sram_gnt;
  assign w_off  = r_addr[OW-1:0];
  assign w_base = {fill_addr[ADDR_W-1:OW], {OW{1'b0}}};
  // Offset wraps inside the line, so the address never leaves it.
  assign w_next = {r_base[ADDR_W-1:OW], w_off + OW'(1)};

`ifdef IBEX_IMEM_FILL_CRIT_WORD_FIRST_EN
  assign w_start = fill_addr;
`else
  assign w_start = w_base;
`endif

  assign w_we = (r_st == S_WAIT) & sram_rvalid & ~fill_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_base  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_first <= 1'b1;
    end else begin
      r_done  <= 1'b0;
      r_first <= 1'b0;
      // Data still in flight from before reset may land now.
      if (sram_rvalid && !r_first &&
          (r_st == S_IDLE || r_st == S_REQ))
        r_err <= 1'b1;
      unique case (r_st)
        S_IDLE: begin
          if (fill_req) begin
            r_base <= w_base;
            r_addr <= w_start;
            r_cnt  <= '0;
            r_req  <= 1'b1;
            r_st   <= S_REQ;
          end
        end
        S_REQ: begin
          if (fill_abort) begin
            r_req <= 1'b0;
            r_st  <= w_hs ? S_DRAIN : S_IDLE;
          end else if (w_hs) begin
            r_req <= 1'b0;
            r_st  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A word arriving with the abort is simply dropped.
          if (fill_abort) begin
            r_st <= sram_rvalid ? S_IDLE : S_DRAIN;
          end else if (sram_rvalid) begin
            if (r_cnt == LAST) begin
              r_done <= 1'b1;
              r_st   <= S_IDLE;
            end else begin
              r_cnt  <= r_cnt + OW'(1);
              r_addr <= w_next;
              r_req  <= 1'b1;
              r_st   <= S_REQ;
            end
          end
        end
        S_DRAIN: begin
          if (sram_rvalid)
            r_st <= S_IDLE;
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

  ibex_imem_line_buf #(
    .LINE_WORDS (LINE_WORDS),
    .OW         (OW)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we),
    .i_slot (w_off),
    .i_data (sram_rdata),
    .o_line (fill_line)
  );

  assign fill_ready = (r_st == S_IDLE);
  assign fill_done  = r_done;
  assign fill_base  = r_base;
  assign sram_req   = r_req;
  assign sram_addr  = r_addr;
  assign proto_err  = r_err;

endmodule

// File: tb/tb_ibex_imem_fill.sv
// Self-checking bench for ibex_imem_fill with a modelled imem.
// Address order follows IBEX_IMEM_FILL_CRIT_WORD_FIRST_EN.
module tb_ibex_imem_fill;

  logic         clk = 1'b0;
  logic         rst;
  logic         fill_req;
  logic [9:0]   fill_addr;
  logic         fill_abort;
  logic         fill_ready;
  logic         fill_done;
  logic [9:0]   fill_base;
  logic [127:0] fill_line;
  logic         sram_req;
  logic [9:0]   sram_addr;
  logic         sram_gnt;
  logic         sram_rvalid;
  logic [31:0]  sram_rdata;
  logic         proto_err;

  logic         rsp_gnt  = 1'b0;
  logic         rsp_rv   = 1'b0;
  logic [31:0]  rsp_data = '0;
  logic         inj_rv   = 1'b0;

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int t_acc    = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  ibex_imem_fill dut (
    .clk         (clk),
    .rst         (rst),
    .fill_req    (fill_req),
    .fill_addr   (fill_addr),
    .fill_abort  (fill_abort),
    .fill_ready  (fill_ready),
    .fill_done   (fill_done),
    .fill_base   (fill_base),
    .fill_line   (fill_line),
    .sram_req    (sram_req),
    .sram_addr   (sram_addr),
    .sram_gnt    (sram_gnt),
    .sram_rvalid (sram_rvalid),
    .sram_rdata  (sram_rdata),
    .proto_err   (proto_err)
  );

  assign sram_gnt    = rsp_gnt;
  assign sram_rvalid = rsp_rv | inj_rv;
  assign sram_rdata  = rsp_data;

  // imem responder: registered grant, data one cycle after handshake
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rsp_gnt  <= sram_req && !rsp_gnt;
    rsp_rv   <= sram_req && rsp_gnt;
    rsp_data <= 32'hA000_0000 + 32'(sram_addr);
  end

  // scoreboard: every handshake address must match the next expected one
  always @(negedge clk) begin
    if (fill_done) done_cnt++;
    if (sram_req && sram_gnt) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL hs_unexpected got addr %h exp none", sram_addr);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (sram_addr !== e) begin
          n_fail++;
          $display("FAIL hs_addr got %h exp %h", sram_addr, e);
        end
      end
    end
  end

  function automatic logic [9:0] exp_addr(input logic [9:0] a, input int k);
    logic [1:0] off;
`ifdef IBEX_IMEM_FILL_CRIT_WORD_FIRST_EN
    off = a[1:0] + 2'(k);
`else
    off = 2'(k);
`endif
    return {a[9:2], off};
  endfunction

  function automatic logic [127:0] full_line(input logic [9:0] base);
    logic [127:0] l;
    for (int i = 0; i < 4; i++)
      l[i*32 +: 32] = 32'hA000_0000 + 32'(base) + 32'(i);
    return l;
  endfunction

  task automatic start_fill(input logic [9:0] a, input int n);
    @(negedge clk);
    fill_req  = 1'b1;
    fill_addr = a;
    t_acc     = cyc;
    for (int k = 0; k < n; k++) exp_q.push_back(exp_addr(a, k));
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (fill_done) ok = 1'b1;
    end
  endtask

  task automatic wait_hs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (sram_req && sram_gnt) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    fill_req = 1'b0;
    fill_addr = '0;
    fill_abort = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (sram_req !== 1'b0 || sram_addr !== 10'h0) begin
      n_fail++;
      $display("FAIL rst_sram got %b/%h exp 0/000", sram_req, sram_addr);
    end
    n_tests++;
    if (fill_done !== 1'b0 || proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags got %b/%b exp 0/0", fill_done, proto_err);
    end
    n_tests++;
    if (fill_line !== 128'h0 || fill_base !== 10'h0) begin
      n_fail++;
      $display("FAIL rst_line got %h/%h exp 0/0", fill_line, fill_base);
    end
    n_tests++;
    if (fill_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready got %b exp 1", fill_ready);
    end
  endtask

  task automatic test_basic_fill;
    bit ok;
    start_fill(10'h013, 4);
    wait_done(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_done got timeout exp pulse");
    end
    n_tests++;
    if (cyc !== t_acc + 13) begin
      n_fail++;
      $display("FAIL basic_latency got %0d exp %0d", cyc - t_acc, 13);
    end
    n_tests++;
    if (fill_line !== full_line(10'h010)) begin
      n_fail++;
      $display("FAIL basic_line got %h exp %h", fill_line, full_line(10'h010));
    end
    n_tests++;
    if (fill_base !== 10'h010) begin
      n_fail++;
      $display("FAIL basic_base got %h exp 010", fill_base);
    end
    @(negedge clk);
    n_tests++;
    if (fill_done !== 1'b0 || fill_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_pulse got %b/%b exp 0/1", fill_done, fill_ready);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (fill_line !== full_line(10'h010) || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_hold got %h/%0d exp %h/0",
               fill_line, exp_q.size(), full_line(10'h010));
    end
  endtask

  task automatic test_abort_req;
    int d0;
    d0 = done_cnt;
    start_fill(10'h020, 0);
    fill_abort = 1'b1;
    @(negedge clk);
    fill_abort = 1'b0;
    n_tests++;
    if (sram_req !== 1'b0 || fill_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abreq_idle got %b/%b exp 0/1", sram_req, fill_ready);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (done_cnt != d0 || proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL abreq_quiet got %0d/%b exp %0d/0",
               done_cnt, proto_err, d0);
    end
  endtask

  task automatic test_abort_gnt;
    bit ok;
    int d0;
    d0 = done_cnt;
    start_fill(10'h030, 1);
    wait_hs(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL abgnt_hs got timeout exp handshake");
    end
    fill_abort = 1'b1;
    @(negedge clk);
    fill_abort = 1'b0;
    n_tests++;
    if (fill_ready !== 1'b0 || sram_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL abgnt_drain got %b/%b exp 0/1", fill_ready, sram_rvalid);
    end
    @(negedge clk);
    n_tests++;
    if (fill_ready !== 1'b1 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL abgnt_idle got %b/%0d exp 1/%0d", fill_ready, done_cnt, d0);
    end
    n_tests++;
    if (fill_line !== full_line(10'h010) || fill_base !== 10'h030 ||
        proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL abgnt_line got %h/%h/%b exp %h/030/0",
               fill_line, fill_base, proto_err, full_line(10'h010));
    end
  endtask

  task automatic test_abort_wait;
    bit ok;
    int d0;
    logic [127:0] l;
    d0 = done_cnt;
    l = full_line(10'h010);
    l[31:0] = 32'hA000_0040;
    start_fill(10'h040, 2);
    wait_hs(ok);
    @(negedge clk);
    wait_hs(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL abwait_hs got timeout exp handshake");
    end
    @(negedge clk);
    fill_abort = 1'b1;
    @(negedge clk);
    fill_abort = 1'b0;
    n_tests++;
    if (fill_ready !== 1'b1 || fill_line !== l) begin
      n_fail++;
      $display("FAIL abwait_line got %b/%h exp 1/%h", fill_ready, fill_line, l);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (done_cnt != d0 || proto_err !== 1'b0 || sram_req !== 1'b0) begin
      n_fail++;
      $display("FAIL abwait_quiet got %0d/%b/%b exp %0d/0/0",
               done_cnt, proto_err, sram_req, d0);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int d0;
    d0 = done_cnt;
    start_fill(10'h050, 2);
    wait_hs(ok);
    @(negedge clk);
    wait_hs(ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (sram_req !== 1'b0 || fill_ready !== 1'b1 || fill_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_ctl got %b/%b/%b exp 0/1/0",
               sram_req, fill_ready, fill_done);
    end
    n_tests++;
    if (fill_line !== 128'h0 || fill_base !== 10'h0) begin
      n_fail++;
      $display("FAIL rstmid_line got %h/%h exp 0/0", fill_line, fill_base);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (proto_err !== 1'b0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL rstmid_err got %b/%0d exp 0/%0d", proto_err, done_cnt, d0);
    end
    start_fill(10'h020, 4);
    wait_done(ok);
    n_tests++;
    if (!ok || cyc !== t_acc + 13) begin
      n_fail++;
      $display("FAIL rstmid_refill got %b/%0d exp 1/13", ok, cyc - t_acc);
    end
    n_tests++;
    if (fill_line !== full_line(10'h020) || fill_base !== 10'h020) begin
      n_fail++;
      $display("FAIL rstmid_rline got %h/%h exp %h/020",
               fill_line, fill_base, full_line(10'h020));
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int t0;
    @(negedge clk);
    fill_req  = 1'b1;
    fill_addr = 10'h040;
    t0 = cyc;
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_addr(10'h040, k));
    @(negedge clk);
    fill_addr = 10'h062;
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_addr(10'h062, k));
    wait_done(ok);
    n_tests++;
    if (!ok || cyc !== t0 + 13 || fill_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first got %b/%0d/%b exp 1/13/1",
               ok, cyc - t0, fill_ready);
    end
    n_tests++;
    if (fill_line !== full_line(10'h040) || fill_base !== 10'h040) begin
      n_fail++;
      $display("FAIL b2b_line1 got %h/%h exp %h/040",
               fill_line, fill_base, full_line(10'h040));
    end
    @(negedge clk);
    fill_req = 1'b0;
    n_tests++;
    if (fill_ready !== 1'b0 || fill_base !== 10'h060) begin
      n_fail++;
      $display("FAIL b2b_accept got %b/%h exp 0/060", fill_ready, fill_base);
    end
    repeat (3) @(negedge clk);
    fill_req  = 1'b1;
    fill_addr = 10'h070;
    @(negedge clk);
    fill_req = 1'b0;
    wait_done(ok);
    n_tests++;
    if (!ok || cyc !== t0 + 26) begin
      n_fail++;
      $display("FAIL b2b_second got %b/%0d exp 1/26", ok, cyc - t0);
    end
    n_tests++;
    if (fill_line !== full_line(10'h060) || fill_base !== 10'h060) begin
      n_fail++;
      $display("FAIL b2b_line2 got %h/%h exp %h/060",
               fill_line, fill_base, full_line(10'h060));
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0 || sram_req !== 1'b0 || fill_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ignored got %0d/%b/%b exp 0/0/1",
               exp_q.size(), sram_req, fill_ready);
    end
  endtask

  task automatic test_proto_err;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    n_tests++;
    if (proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_pre got %b exp 0", proto_err);
    end
    inj_rv = 1'b1;
    @(negedge clk);
    inj_rv = 1'b0;
    n_tests++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_set got %b exp 1", proto_err);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (proto_err !== 1'b1 || fill_ready !== 1'b1 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL perr_sticky got %b/%b/%0d exp 1/1/%0d",
               proto_err, fill_ready, done_cnt, d0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic_fill;
    test_abort_req;
    test_abort_gnt;
    test_abort_wait;
    test_reset_mid;
    test_back_to_back;
    test_proto_err;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
